stream_rr_arbiter: RTL and testbench



---
 rtl/stream_rr_arbiter_pkg.sv | 35 +++
 rtl/stream_rr_arbiter_if.sv | 29 ++
 rtl/skid_buffer.sv | 45 ++++
 rtl/stream_rr_arbiter_rr_grant_select.sv | 24 ++
 rtl/stream_rr_arbiter.sv | 113 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and the round-robin scan function for stream_rr_arbiter.
// Used by the grant selector and by the top-level FSM.
package stream_arb_pkg;

    localparam int NUM_REQ_MAX = 16;
    localparam int REQ_IDX_W   = $clog2(NUM_REQ_MAX);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [REQ_IDX_W-1:0] idx;
    } rr_pick_t;

    // Unused upper bits of valid must be zero. The scan then wraps modulo
    // NUM_REQ_MAX, which visits real requesters in ptr+1 .. ptr modulo NUM_REQ order.
    function automatic rr_pick_t rr_next(input logic [NUM_REQ_MAX-1:0] valid,
                                         input logic [REQ_IDX_W-1:0]   ptr);
        rr_pick_t             pick;
        logic [REQ_IDX_W-1:0] k;
        pick = '0;
        for (int i = 1; i <= NUM_REQ_MAX; i++) begin
            k = ptr + REQ_IDX_W'(i);
            if (!pick.found && valid[k]) begin
                pick.found = 1'b1;
                pick.idx   = k;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundles the requester-side and consumer-side stream signals of stream_rr_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = 8
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            i_valid;
    logic [NUM_REQ-1:0]            i_ready;
    logic [NUM_REQ*WORD_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            i_last;
    logic                          o_valid;
    logic                          o_ready;
    logic [WORD_WIDTH-1:0]         o_data;
    logic                          o_last;
    logic [ID_WIDTH-1:0]           o_id;

    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output i_ready, o_valid, o_data, o_last, o_id
    );

    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  i_ready, o_valid, o_data, o_last, o_id
    );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with fully registered outputs.
// in_ready depends only on the skid register, which breaks the ready path.
module skid_buffer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data
);

    logic                  skid_valid;
    logic [WORD_WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid;

    // The skid entry catches the beat accepted while the output register is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter_rr_grant_select.sv
// Combinational round-robin pick: the first set bit of valid after ptr,
// wrapping modulo NUM_REQ.
module rr_grant_select
    import stream_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_next(NUM_REQ_MAX'(valid), REQ_IDX_W'(ptr));
    end

    assign idx   = ID_WIDTH'(pick.idx);
    assign found = pick.found;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready streams into one skid-buffered stream tagged with o_id.
// Define STREAM_ARB_PKT_LOCK_EN to hold each grant until the packet's last beat; otherwise beats interleave.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int WORD_WIDTH = 8,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    stream_rr_arbiter_if.slave bus
);

    localparam int BEAT_WIDTH = WORD_WIDTH + 1 + ID_WIDTH;

    state_t                state;
    state_t                state_n;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   grant_n;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_n;
    logic [ID_WIDTH-1:0]   scan_ptr;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_found;
    logic [NUM_REQ-1:0]    ready_vec;
    logic                  stage_valid;
    logic                  stage_ready;
    logic                  accept;
    logic                  end_grant;
    logic [BEAT_WIDTH-1:0] stage_in;
    logic [BEAT_WIDTH-1:0] stage_out;

    // When a grant ends, the finishing requester becomes the new pointer, so the scan starts just after it.
    assign scan_ptr = (state == GRANTED) ? grant : ptr;

    rr_grant_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .valid (bus.i_valid),
        .ptr   (scan_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        ptr_n       = ptr;
        ready_vec   = '0;
        stage_valid = 1'b0;
        accept      = 1'b0;
        end_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANTED;
                    grant_n = pick_idx;
                end
            end
            GRANTED: begin
                ready_vec[grant] = stage_ready;
                stage_valid      = bus.i_valid[grant];
                accept           = stage_valid && stage_ready;
`ifdef STREAM_ARB_PKT_LOCK_EN
                end_grant        = accept && bus.i_last[grant];
`else
                end_grant        = accept;
`endif
                // Re-arbitrating on the accepting edge avoids a bubble between packets.
                if (end_grant) begin
                    ptr_n = grant;
                    if (pick_found) begin
                        grant_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    assign stage_in = {grant, bus.i_last[grant], bus.i_data[int'(grant)*WORD_WIDTH +: WORD_WIDTH]};

    skid_buffer #(
        .WORD_WIDTH (BEAT_WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .reset     (!reset_n),
        .in_valid  (stage_valid),
        .in_ready  (stage_ready),
        .in_data   (stage_in),
        .out_valid (bus.o_valid),
        .out_ready (bus.o_ready),
        .out_data  (stage_out)
    );

    assign bus.i_ready = ready_vec;
    assign {bus.o_id, bus.o_last, bus.o_data} = stage_out;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter: a per-cycle vector table plus
// sequences for fairness, backpressure, lock/bubble, reset and re-grant. Follows STREAM_ARB_PKT_LOCK_EN.
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    stream_rr_arbiter_if #(.NUM_REQ(4), .WORD_WIDTH(8)) bus ();

    stream_rr_arbiter #(
        .NUM_REQ    (4),
        .WORD_WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       o_ready;
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] data;
        logic [3:0] exp_ready;
        logic       exp_ovalid;
        logic [7:0] exp_odata;
        logic       exp_olast;
        logic [1:0] exp_oid;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    int         total = 0;
    int         bad = 0;
    int         cyc;
    int         cnt[4];
    int         cfg_start[4];
    int         cfg_lim[4];
    int         cfg_plen[4];
    logic [7:0] cfg_base[4];
    int         gap_req, gap_from, gap_to;
    int         rst_at, stall_from, stall_to;
    beat_t      got[$];
    vec_t       vecs[6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string name, input int n, input logic [1:0] id,
                              input logic [7:0] data, input logic last);
        if (n >= got.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL %s[%0d]: got no beat want id=%0d data=%h last=%0d", name, n, id, data, last);
        end else begin
            check_output($sformatf("%s[%0d]", name, n), {got[n].id, got[n].last, got[n].data}, {id, last, data});
        end
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < 4; k++) begin
            cfg_start[k] = 0;
            cfg_lim[k]   = 0;
            cfg_plen[k]  = 1;
            cfg_base[k]  = 8'h00;
        end
        gap_req    = -1;
        gap_from   = -1;
        gap_to     = -2;
        rst_at     = -1;
        stall_from = -1;
        stall_to   = -2;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.i_valid[k]      = (cyc >= cfg_start[k]) && (cnt[k] < cfg_lim[k]) &&
                                  !(k == gap_req && cyc >= gap_from && cyc <= gap_to);
            bus.i_data[k*8 +: 8] = cfg_base[k] + 8'(cnt[k]);
            bus.i_last[k]       = ((cnt[k] + 1) % cfg_plen[k]) == 0;
        end
        bus.o_ready = !(cyc >= stall_from && cyc <= stall_to);
        reset_n     = (cyc != rst_at);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.i_valid = '0;
        bus.i_last  = '0;
        bus.i_data  = '0;
        bus.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        got.delete();
        drive_inputs();
    endtask

    // Called at a negedge: records this cycle's transfers, then advances one clock.
    task automatic tick();
        logic [3:0] acc;
        acc = bus.i_valid & bus.i_ready;
        if (bus.o_valid && bus.o_ready)
            got.push_back('{id: bus.o_id, data: bus.o_data, last: bus.o_last, cyc: cyc});
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (acc[k]) cnt[k]++;
        cyc++;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.o_ready = v.o_ready;
        bus.i_valid = v.valid;
        bus.i_last  = v.last;
        bus.i_data  = {4{v.data}};
    endtask

    initial begin
        logic [7:0] lk_data[4];
        logic [1:0] lk_id[4];
        int         id, c;

        // Requester 2 sends 0x11, 0x12, 0x13 (last) with the consumer always ready.
        vecs[0] = '{1'b1, 4'b0100, 4'b0000, 8'h11, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 4'b0100, 4'b0000, 8'h11, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 4'b0100, 4'b0000, 8'h12, 4'b0100, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[3] = '{1'b1, 4'b0100, 4'b0100, 8'h13, 4'b0100, 1'b1, 8'h12, 1'b0, 2'd2};
        vecs[4] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0100, 1'b1, 8'h13, 1'b1, 2'd2};
        vecs[5] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};

        clear_cfg();
        do_reset();
        @(negedge clk);
        check_output("reset_state", {bus.i_ready, bus.o_valid, bus.o_data, bus.o_last, bus.o_id}, 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            if (vecs[i].exp_ovalid)
                check_output($sformatf("single_c%0d", i),
                             {bus.i_ready, bus.o_valid, bus.o_data, bus.o_last, bus.o_id},
                             {vecs[i].exp_ready, vecs[i].exp_ovalid, vecs[i].exp_odata, vecs[i].exp_olast, vecs[i].exp_oid});
            else
                check_output($sformatf("single_c%0d", i), {bus.i_ready, bus.o_valid},
                             {vecs[i].exp_ready, vecs[i].exp_ovalid});
            @(posedge clk);
            #1;
        end

        // Fairness: all four requesters stream 2-beat packets.
        clear_cfg();
        for (int k = 0; k < 4; k++) begin
            cfg_lim[k]  = 100;
            cfg_plen[k] = 2;
            cfg_base[k] = 8'(k * 16);
        end
        do_reset();
        @(negedge clk);
        repeat (12) tick();
        check_output("fair_count", 32'(got.size() >= 8), 32'd1);
        for (int n = 0; n < 8; n++) begin
`ifdef STREAM_ARB_PKT_LOCK_EN
            id = (n / 2) % 4;
            c  = n % 2;
`else
            id = n % 4;
            c  = n / 4;
`endif
            check_beat("fair", n, 2'(id), 8'(id * 16 + c), c == 1);
        end
        if (got.size() >= 8) begin
            check_output("fair_first_cycle", got[0].cyc, 2);
            check_output("fair_span", got[7].cyc - got[0].cyc, 7);
        end

        // Backpressure: requester 1 sends 4 beats while the consumer stalls for 5 cycles.
        clear_cfg();
        cfg_lim[1]  = 4;
        cfg_plen[1] = 4;
        cfg_base[1] = 8'h40;
        stall_from  = 3;
        stall_to    = 7;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            if (cyc >= 3 && cyc <= 7)
                check_output($sformatf("bp_hold_c%0d", cyc), {bus.o_valid, bus.o_last, bus.o_id, bus.o_data},
                             {1'b1, 1'b0, 2'd1, 8'h41});
            if (cyc >= 4 && cyc <= 7)
                check_output($sformatf("bp_ready_c%0d", cyc), bus.i_ready, 4'b0000);
            tick();
        end
        check_output("bp_count", got.size(), 4);
        for (int n = 0; n < 4; n++) check_beat("bp", n, 2'd1, 8'h40 + 8'(n), n == 3);

        // Lock vs bubble: requester 1 pauses mid-packet while requester 3 waits.
        clear_cfg();
        cfg_lim[1]  = 3;
        cfg_plen[1] = 3;
        cfg_base[1] = 8'h50;
        cfg_start[3] = 2;
        cfg_lim[3]  = 1;
        cfg_plen[3] = 1;
        cfg_base[3] = 8'h70;
        gap_req     = 1;
        gap_from    = 2;
        gap_to      = 4;
`ifdef STREAM_ARB_PKT_LOCK_EN
        lk_data = '{8'h50, 8'h51, 8'h52, 8'h70};
        lk_id   = '{2'd1, 2'd1, 2'd1, 2'd3};
`else
        lk_data = '{8'h50, 8'h51, 8'h70, 8'h52};
        lk_id   = '{2'd1, 2'd1, 2'd3, 2'd1};
`endif
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (cyc >= 2 && cyc <= 4)
                check_output($sformatf("lock_bubble_c%0d", cyc), bus.i_ready, 4'b0010);
            tick();
        end
        check_output("lock_count", got.size(), 4);
        for (int n = 0; n < 4; n++) check_beat("lock", n, lk_id[n], lk_data[n], n >= 2);

        // Reset with two beats buffered, then requesters 0 and 1 compete.
        clear_cfg();
        cfg_lim[0]   = 8;
        cfg_plen[0]  = 8;
        cfg_base[0]  = 8'h20;
        cfg_start[1] = 4;
        cfg_lim[1]   = 1;
        cfg_plen[1]  = 1;
        cfg_base[1]  = 8'h30;
        stall_from   = 2;
        stall_to     = 4;
        rst_at       = 3;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (cyc == 4)
                check_output("rst_clear", {bus.i_ready, bus.o_valid, bus.o_data, bus.o_last, bus.o_id}, 32'h0);
            if (cyc == 5)
                check_output("rst_regrant", bus.i_ready, 4'b0001);
            tick();
        end
        check_beat("rst_first", 0, 2'd0, 8'h22, 1'b0);

        // Requester 0 alone sends back-to-back single-beat packets.
        clear_cfg();
        cfg_lim[0]  = 4;
        cfg_plen[0] = 1;
        cfg_base[0] = 8'h90;
        do_reset();
        @(negedge clk);
        repeat (9) tick();
        check_output("sole_count", got.size(), 4);
        for (int n = 0; n < 4; n++) check_beat("sole", n, 2'd0, 8'h90 + 8'(n), 1'b1);
        if (got.size() == 4) check_output("sole_span", {got[0].cyc[7:0], got[3].cyc[7:0]}, {8'd2, 8'd5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
